// File: rtl/mem_arbiter_if.sv
// Per-master request/response bundle for mem_arbiter: the bus master drives the
// request side, the arbiter returns grant and registered read data.
interface mem_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-port word memory, with a bounded
// ownership lock for read-modify-write sequences and registered read return.
module mem_arbiter #(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_async_n,
   mem_arbiter_if.slave      m0,
   mem_arbiter_if.slave      m1,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_write_en,
   output logic [DATA_W-1:0] mem_write_value,
   input  logic [DATA_W-1:0] mem_read_value
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_t;

   localparam logic [3:0] LC_MAX = 4'(LOCK_MAX);

   own_t              r_own;
   logic              r_last;
   logic [3:0]        r_lock_cnt;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   logic w_lock_ok;
   logic w_hold0;
   logic w_hold1;
   logic w_rr0;
   logic w_rr1;
   logic w_gnt0;
   logic w_gnt1;
   logic w_any;
   logic w_win_lock;
   own_t w_own_win;

   assign w_lock_ok = (r_lock_cnt < LC_MAX);
   assign w_hold0   = (r_own == OWN0) && m0.req && w_lock_ok;
   assign w_hold1   = (r_own == OWN1) && m1.req && w_lock_ok;

   // On a tie the master that was not granted last wins; an expired lock falls
   // through to this path with r_last already pointing at the previous owner.
   assign w_rr0 = m0.req && (!m1.req || r_last);
   assign w_rr1 = m1.req && (!m0.req || !r_last);

   assign w_gnt0 = rst_async_n && (w_hold0 || (!w_hold1 && w_rr0));
   assign w_gnt1 = rst_async_n && (w_hold1 || (!w_hold0 && w_rr1));

   assign w_any      = w_gnt0 || w_gnt1;
   assign w_win_lock = w_gnt0 ? m0.lock : m1.lock;
   assign w_own_win  = w_gnt1 ? OWN1 : OWN0;

   assign m0.gnt    = w_gnt0;
   assign m1.gnt    = w_gnt1;
   assign m0.rvalid = r_rvalid0;
   assign m1.rvalid = r_rvalid1;
   assign m0.rdata  = r_rdata0;
   assign m1.rdata  = r_rdata1;

   always_comb begin
      mem_address     = '0;
      mem_write_value = '0;
      mem_write_en    = 1'b0;
      if (w_gnt0) begin
         mem_address     = m0.addr;
         mem_write_value = m0.wdata;
         mem_write_en    = m0.we;
      end else if (w_gnt1) begin
         mem_address     = m1.addr;
         mem_write_value = m1.wdata;
         mem_write_en    = m1.we;
      end
   end

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         r_own      <= IDLE;
         r_last     <= 1'b1;
         r_lock_cnt <= '0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         r_rvalid0 <= w_gnt0 && !m0.we;
         r_rvalid1 <= w_gnt1 && !m1.we;
         if (w_gnt0 && !m0.we) r_rdata0 <= mem_read_value;
         if (w_gnt1 && !m1.we) r_rdata1 <= mem_read_value;

         if (w_any) begin
            r_last <= w_gnt1;
            if (w_win_lock) begin
               r_own <= w_own_win;
               // Continuing an unexpired lock counts up; a fresh or re-won lock restarts at 1.
               if (r_own == w_own_win && w_lock_ok) r_lock_cnt <= r_lock_cnt + 4'd1;
               else                                 r_lock_cnt <= 4'd1;
            end else begin
               r_own      <= IDLE;
               r_lock_cnt <= '0;
            end
         end else begin
            r_own      <= IDLE;
            r_lock_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a full-size word memory model.
module tb_mem_arbiter;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst_async_n;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_write_en;
   logic [DATA_W-1:0] mem_write_value;
   logic [DATA_W-1:0] mem_read_value;

   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [DATA_W-1:0] pre_data;

   bit [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int n_tests;
   int n_fail;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

   mem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .LOCK_MAX (4)
   ) dut (
      .clk             (clk),
      .rst_async_n     (rst_async_n),
      .m0              (m0_if.slave),
      .m1              (m1_if.slave),
      .mem_address     (mem_address),
      .mem_write_en    (mem_write_en),
      .mem_write_value (mem_write_value),
      .mem_read_value  (mem_read_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_value = mem[mem_address];

   always @(posedge clk) begin
      if (mem_write_en)  mem[mem_address] <= mem_write_value;
      else if (pre_we)   mem[pre_addr]    <= pre_data;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we   = 1'b0;
   endtask

   task automatic drive0(input logic req, input logic we, input logic lock,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      m0_if.req = req; m0_if.we = we; m0_if.lock = lock; m0_if.addr = a; m0_if.wdata = d;
   endtask

   task automatic drive1(input logic req, input logic we, input logic lock,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      m1_if.req = req; m1_if.we = we; m1_if.lock = lock; m1_if.addr = a; m1_if.wdata = d;
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst_async_n = 1'b0;
      pre_we      = 1'b0;
      pre_addr    = '0;
      pre_data    = '0;
      drive0(1'b0, 1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, 1'b0, '0, '0);

      preload(20'd10, 32'h1000_0000);
      preload(20'd20, 32'h2000_0000);
      preload(20'd30, 32'h3000_0000);

      // Reset held with both masters requesting (m1 wants a write).
      drive0(1'b1, 1'b0, 1'b0, 20'd10, '0);
      drive1(1'b1, 1'b1, 1'b0, 20'h00055, 32'h0000_beef);
      tick();
      tick();
      #1;
      check("rst_gnt0",   m0_if.gnt, 0);
      check("rst_gnt1",   m1_if.gnt, 0);
      check("rst_we",     mem_write_en, 0);
      check("rst_rv0",    m0_if.rvalid, 0);
      check("rst_rv1",    m1_if.rvalid, 0);
      check("rst_rdata0", m0_if.rdata, 0);
      check("rst_mem55",  mem[20'h00055], 0);

      rst_async_n = 1'b1;
      #1;
      check("first_gnt0", m0_if.gnt, 1);
      check("first_gnt1", m1_if.gnt, 0);
      check("first_addr", mem_address, 20'd10);
      check("first_we",   mem_write_en, 0);

      // Single read returns next cycle; pending m1 write then goes through.
      tick();
      m0_if.req = 1'b0;
      #1;
      check("rd_rv0",     m0_if.rvalid, 1);
      check("rd_rdata0",  m0_if.rdata, 32'h1000_0000);
      check("wr_gnt1",    m1_if.gnt, 1);
      check("wr_we",      mem_write_en, 1);
      check("wr_addr",    mem_address, 20'h00055);
      check("wr_val",     mem_write_value, 32'h0000_beef);
      tick();
      m1_if.req = 1'b0;
      #1;
      check("rd_rv0_once", m0_if.rvalid, 0);
      check("wr_no_rv1",   m1_if.rvalid, 0);
      check("wr_mem55",    mem[20'h00055], 32'h0000_beef);

      // Contention: both read every cycle, grants alternate starting with m0.
      drive0(1'b1, 1'b0, 1'b0, 20'd20, '0);
      drive1(1'b1, 1'b0, 1'b0, 20'd30, '0);
      #1;
      for (int i = 0; i < 6; i++) begin
         check("cont_gnt0", m0_if.gnt, (i % 2 == 0));
         check("cont_gnt1", m1_if.gnt, (i % 2 == 1));
         tick();
         #1;
         check("cont_rv0", m0_if.rvalid, (i % 2 == 0));
         check("cont_rv1", m1_if.rvalid, (i % 2 == 1));
      end
      check("cont_rdata0", m0_if.rdata, 32'h2000_0000);
      check("cont_rdata1", m1_if.rdata, 32'h3000_0000);

      // m1 write to top address against m0 reads: write only in m1's grant cycle.
      drive0(1'b1, 1'b0, 1'b0, 20'd10, '0);
      drive1(1'b1, 1'b1, 1'b0, 20'hfffff, 32'h0000_dead);
      #1;
      check("wp_gnt0_a", m0_if.gnt, 1);
      check("wp_gnt1_a", m1_if.gnt, 0);
      check("wp_we_a",   mem_write_en, 0);
      check("wp_addr_a", mem_address, 20'd10);
      tick();
      #1;
      check("wp_gnt1_b", m1_if.gnt, 1);
      check("wp_gnt0_b", m0_if.gnt, 0);
      check("wp_we_b",   mem_write_en, 1);
      check("wp_addr_b", mem_address, 20'hfffff);
      check("wp_val_b",  mem_write_value, 32'h0000_dead);
      check("wp_mem_pre", mem[20'hfffff], 0);
      tick();
      drive0(1'b0, 1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("wp_mem_post", mem[20'hfffff], 32'h0000_dead);

      // Lock: m0 holds for 4 grants, m1 gets one, m0 re-takes ownership.
      drive0(1'b1, 1'b0, 1'b1, 20'd10, '0);
      drive1(1'b1, 1'b0, 1'b0, 20'd30, '0);
      #1;
      for (int i = 0; i < 8; i++) begin
         check("lock_gnt0", m0_if.gnt, (i != 4));
         check("lock_gnt1", m1_if.gnt, (i == 4));
         tick();
         #1;
      end

      // m0 releases; m1 takes a locked read, then reset lands mid-cycle.
      drive0(1'b0, 1'b0, 1'b0, '0, '0);
      drive1(1'b1, 1'b0, 1'b1, 20'd30, '0);
      #1;
      check("rel_gnt1", m1_if.gnt, 1);
      tick();
      check("mr_rv1_pre",    m1_if.rvalid, 1);
      check("mr_rdata1_pre", m1_if.rdata, 32'h3000_0000);
      rst_async_n = 1'b0;
      #1;
      check("mr_rv1",    m1_if.rvalid, 0);
      check("mr_rdata1", m1_if.rdata, 0);
      check("mr_gnt1",   m1_if.gnt, 0);
      drive0(1'b1, 1'b0, 1'b0, 20'd20, '0);
      tick();
      #1;
      check("mr_gnt0_rst", m0_if.gnt, 0);
      rst_async_n = 1'b1;
      #1;
      check("mr_tie_gnt0", m0_if.gnt, 1);
      check("mr_tie_gnt1", m1_if.gnt, 0);
      tick();
      drive0(1'b0, 1'b0, 1'b0, '0, '0);
      drive1(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("mr_rv0",    m0_if.rvalid, 1);
      check("mr_rdata0", m0_if.rdata, 32'h2000_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port word memory (20-bit word address, 32-bit data, combinational read, write on rising edge) between the wramp core (port 0) and a second bus master such as a loader or DMA engine (port 1). It selects one requester per cycle round-robin and drives the memory port. It registers read data back to the winner, and supports a bounded lock so one master can hold the memory for a read-modify-write sequence.

## Interface
- ADDR_W, 20, word address width on all ports
- DATA_W, 32, data width
- LOCK_MAX, 4, max consecutive locked grants to one master before forced re-arbitration (1..15)
- clk  in  1  system clock, all state on rising edge
- rst_async_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_lock / m1_lock  in  1  request to keep ownership for the next access
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  access performed this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid, one cycle after read grant
- m0_rdata / m1_rdata  out  DATA_W  registered read data
- mem_address  out  ADDR_W  to memory
- mem_write_en  out  1  to memory
- mem_write_value  out  DATA_W  to memory
- mem_read_value  in  DATA_W  from memory, combinational on mem_address

## Operation
- State: own ∈ {IDLE, OWN0, OWN1}; last (1 bit, last granted master); lock_cnt (4 bits).
- Arbitration each cycle, in priority order:
  - own=OWNk, mk_req=1, lock_cnt<LOCK_MAX: grant k.
  - own=OWNk, mk_req=0: lock released, arbitrate round-robin this cycle.
  - Round-robin otherwise: one requester → that one; both → master ≠ last.
- At most one gnt high per cycle. gnt is only asserted when the matching req is high.
- Winner k drives mem_address=mk_addr, mem_write_value=mk_wdata, mem_write_en=mk_we.
- No winner: mem_address=0, mem_write_value=0, mem_write_en=0.
- Updates on grant to k:
  - last←k.
  - If mk_lock=1: own←OWNk. lock_cnt←1 if ownership is newly taken, else lock_cnt+1.
  - If mk_lock=0: own←IDLE, lock_cnt←0.
- Lock expiry: when own=OWNk and lock_cnt==LOCK_MAX, that cycle arbitrates round-robin with last=k. own←IDLE unless k wins again with lock=1, in which case lock_cnt←1.
- Reads: on a read grant to k, mk_rdata←mem_read_value at the clock edge and mk_rvalid=1 for exactly the next cycle. rdata holds until the next read for that master.
- Writes: no rvalid. The memory commits at the grant edge.
- The non-winner sees gnt=0 and holds req/addr/wdata/we/lock stable.

## Timing
- Reset (rst_async_n=0, asynchronous): own=IDLE, last=1 (port 0 wins the first tie), lock_cnt=0. All rvalid=0, all rdata=0. gnt and mem_write_en forced 0 while reset is asserted.
- Grant latency: 0 cycles (same cycle as req when the master wins). Read data latency: 1 cycle after grant.
- Back-to-back: a master may be granted every cycle; rvalid may then be high on consecutive cycles.
- Worst-case wait under contention without lock: 1 cycle. With lock: LOCK_MAX cycles.
- Simultaneous req with own=IDLE, last=0: m1 wins; next contested cycle m0 wins.
- Reset mid-operation: a pending rvalid is dropped, the lock is cleared, and the access in the reset cycle is not performed.
- lock_cnt saturates at LOCK_MAX and never wraps.

## Test plan
- Reset: hold rst_async_n=0 with both req=1 → gnt=0, mem_write_en=0, rvalid=0. Release with both requesting → m0_gnt first.
- Single read: mem[10]=0x10000000, m0 read addr 10 → m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0x10000000.
- Contention: both read every cycle for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1; each rvalid lags its gnt by 1 cycle.
- Write priority check: m1 writes 0xdead to 0xfffff while m0 reads → memory write occurs only in the m1_gnt cycle, with mem_write_en=1 and mem_address=0xfffff.
- Lock: m0 lock=1 and req=1 for 8 cycles with m1 also requesting, LOCK_MAX=4 → m0 granted 4 cycles, then m1 once, then m0 regains ownership.
- Mid-read reset: assert reset in the cycle after a read grant → rvalid=0, own=IDLE; first post-reset tie goes to m0.
